sad_min_tracker: RTL and testbench
==================================

Name: sad_min_tracker

Overview:
- Downstream consumer of the absolute-difference systolic array.
- Each beat carries EDGE_LEN column partial SADs for each of PIXELS_IN_BATCH candidate positions. The block reduces them to one full-block SAD per candidate.
- Over a search frame of NUM_BATCHES beats it tracks the minimum SAD and its candidate index.
- Reports the minimum to the motion-vector stage with a one-cycle done pulse.

Parameters:
- PIXELS_IN_BATCH, 16, candidate positions per beat.
- EDGE_LEN, 8, block edge; number of partials summed per candidate.
- PSAD_BIT_WIDTH, 11, width of each partial SAD.
- SAD_BIT_WIDTH, 14, width of full SAD; default = PSAD_BIT_WIDTH+clog2(EDGE_LEN).
- NUM_BATCHES, 16, beats per search frame (must be ≥1).
- INDEX_BIT_WIDTH, 8, candidate index width; must be ≥ clog2(NUM_BATCHES*PIXELS_IN_BATCH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a frame; honoured only in IDLE.
- psad_valid  in  1  psad_addend_batch carries a beat this cycle.
- psad_addend_batch  in  PSAD_BIT_WIDTH*EDGE_LEN*PIXELS_IN_BATCH  partials. Lane (c,p) = slice index c*PIXELS_IN_BATCH+p, c = column 0..EDGE_LEN-1, p = candidate.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; best_sad/best_index are valid.
- best_sad  out  SAD_BIT_WIDTH  minimum SAD of the last completed frame.
- best_index  out  INDEX_BIT_WIDTH  beat*PIXELS_IN_BATCH+p of the minimum.

Behaviour:
- Reset: FSM→IDLE. busy=0, done=0, best_sad=0, best_index=0. Beat counter, pipeline valids and running minimum are cleared. A reset mid-frame abandons the frame; no done is produced.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE: start=1 → RUN. Clear beat_cnt; running min = all ones; running idx = 0.
  - RUN: each cycle with psad_valid=1 is one beat and increments beat_cnt. The beat with beat_cnt==NUM_BATCHES-1 → DRAIN. psad_valid outside RUN is ignored.
  - DRAIN: wait until both pipeline stages are empty (exactly 2 cycles) → DONE.
  - DONE: done=1 for one cycle; best_sad/best_index load the running min/idx → IDLE.
  - start outside IDLE is ignored. start and psad_valid in the same IDLE cycle: the beat is ignored.
- Pipeline:
  - S1, registered: per candidate p, sum over c of the EDGE_LEN partials. Zero-extended, unsigned adder tree; result SAD_BIT_WIDTH wide.
  - S2, registered: minimum across the PIXELS_IN_BATCH sums of the beat. Tie → lowest p. Index = beat*PIXELS_IN_BATCH+p; the beat number is carried with S1.
  - S3: running compare; update only when the S2 value is strictly less than the running min. Ties keep the earlier index.
  - A beat accepted at cycle t affects the running min at t+3.
  - done asserts 4 cycles after the last beat is accepted (RUN→DRAIN at t+1, DRAIN t+1..t+2, DONE t+3, outputs visible t+4 edge).
- Back-to-back beats every cycle are supported; gaps in psad_valid are allowed; there is no backpressure.
- best_sad/best_index hold their values until the next DONE or rst.
- NUM_BATCHES=1: RUN→DRAIN on the first beat.

Optional Feature:
- Macro SAD_SATURATE_EN.
- Defined: each S1 sum that exceeds 2^SAD_BIT_WIDTH-1 is clamped to all ones. A saturated candidate can still win if all others are also saturated (lowest index).
- Undefined: S1 sums are truncated to SAD_BIT_WIDTH LSBs (wrap). Intended only where SAD_BIT_WIDTH is full width.

Test Plan:
- Reset, then start. 16 beats: all partials 1, except beat 5, candidate 3, where all 8 partials are 0. → done once, 4 cycles after the last beat; best_sad=0, best_index=83.
- All partials equal 10 every beat → best_sad=80, best_index=0 (tie keeps earliest).
- Beats with psad_valid gaps of 0–3 cycles, random data → best_sad/best_index match the reference model; busy high throughout; done pulse width 1.
- rst asserted on beat 9 of a frame. → busy=0, outputs 0, no done. A new start then completes normally.
- start pulsed during RUN, and psad_valid driven in IDLE/DONE. → no effect on count or result.
- SAD_BIT_WIDTH=12, all partials 2047:
  - with SAD_SATURATE_EN → best_sad=4095;
  - without → best_sad = 16376 mod 4096 = 4088.

Source files
------------

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: reduces per-column partial SADs from the absolute-difference
// array to one full SAD per candidate, then tracks the frame minimum and its
// candidate index over NUM_BATCHES beats. A one-cycle done pulse presents the
// result.
//
// Optional feature macro: SAD_SATURATE_EN
//   defined   - per-candidate sums above 2^SAD_BIT_WIDTH-1 clamp to all ones
//   undefined - per-candidate sums wrap to SAD_BIT_WIDTH LSBs
//
// state | meaning
// IDLE  | waiting for start; beats are ignored
// RUN   | accepting beats until beat NUM_BATCHES-1
// DRAIN | letting the S1/S2 pipeline empty (2 cycles)
// DONE  | latch running min into best_*; done pulses on the next cycle
module sad_min_tracker #(
  parameter int PIXELS_IN_BATCH = 16,
  parameter int EDGE_LEN        = 8,
  parameter int PSAD_BIT_WIDTH  = 11,
  parameter int SAD_BIT_WIDTH   = PSAD_BIT_WIDTH + $clog2(EDGE_LEN),
  parameter int NUM_BATCHES     = 16,
  parameter int INDEX_BIT_WIDTH = 8
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic                                              psad_valid,
  input  logic [PSAD_BIT_WIDTH*EDGE_LEN*PIXELS_IN_BATCH-1:0] psad_addend_batch,
  output logic                                              busy,
  output logic                                              done,
  output logic [SAD_BIT_WIDTH-1:0]                          best_sad,
  output logic [INDEX_BIT_WIDTH-1:0]                        best_index
);

  localparam int BEAT_W = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BATCHES - 1);

`ifdef SAD_SATURATE_EN
  // Wide enough to hold the true sum plus at least one bit above SAD width,
  // so overflow is always visible to the clamp.
  localparam int FULL_W = PSAD_BIT_WIDTH + $clog2(EDGE_LEN + 1);
  localparam int ACC_W  = (FULL_W > SAD_BIT_WIDTH) ? FULL_W : SAD_BIT_WIDTH + 1;
  localparam logic [ACC_W-1:0] SAD_MAX =
    {{(ACC_W-SAD_BIT_WIDTH){1'b0}}, {SAD_BIT_WIDTH{1'b1}}};
`else
  // Wrapping sum: accumulating modulo 2^SAD_BIT_WIDTH gives the LSBs directly.
  localparam int ACC_W = SAD_BIT_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                     state;
  logic [BEAT_W-1:0]          beat_cnt;
  logic                       beat_ok;

  logic [ACC_W-1:0]           acc      [PIXELS_IN_BATCH];
  logic [SAD_BIT_WIDTH-1:0]   cand_sum [PIXELS_IN_BATCH];

  logic                       s1_valid;
  logic [SAD_BIT_WIDTH-1:0]   s1_sum   [PIXELS_IN_BATCH];
  logic [BEAT_W-1:0]          s1_beat;

  logic [SAD_BIT_WIDTH-1:0]   min_sad;
  logic [INDEX_BIT_WIDTH-1:0] min_p;
  logic [INDEX_BIT_WIDTH-1:0] min_idx;

  logic                       s2_valid;
  logic [SAD_BIT_WIDTH-1:0]   s2_sad;
  logic [INDEX_BIT_WIDTH-1:0] s2_idx;

  logic [SAD_BIT_WIDTH-1:0]   run_sad;
  logic [INDEX_BIT_WIDTH-1:0] run_idx;

  assign beat_ok = (state == RUN) && psad_valid;

  // S1 combinational: sum the EDGE_LEN column partials of each candidate.
  always_comb begin
    for (int p = 0; p < PIXELS_IN_BATCH; p++) begin
      acc[p] = '0;
      for (int c = 0; c < EDGE_LEN; c++)
        acc[p] = acc[p] + ACC_W'(psad_addend_batch[(c*PIXELS_IN_BATCH+p)*PSAD_BIT_WIDTH +: PSAD_BIT_WIDTH]);
`ifdef SAD_SATURATE_EN
      cand_sum[p] = (acc[p] > SAD_MAX) ? {SAD_BIT_WIDTH{1'b1}} : acc[p][SAD_BIT_WIDTH-1:0];
`else
      cand_sum[p] = acc[p];
`endif
    end
  end

  // S2 combinational: per-beat minimum; strict compare keeps the lowest p on ties.
  always_comb begin
    min_sad = s1_sum[0];
    min_p   = '0;
    for (int p = 1; p < PIXELS_IN_BATCH; p++) begin
      if (s1_sum[p] < min_sad) begin
        min_sad = s1_sum[p];
        min_p   = INDEX_BIT_WIDTH'(p);
      end
    end
    min_idx = INDEX_BIT_WIDTH'(s1_beat) * INDEX_BIT_WIDTH'(PIXELS_IN_BATCH) + min_p;
  end

  // Pipeline data registers; qualified by s1_valid/s2_valid so no reset needed.
  always_ff @(posedge clk) begin
    s1_sum  <= cand_sum;
    s1_beat <= beat_cnt;
    s2_sad  <= min_sad;
    s2_idx  <= min_idx;
  end

  // Control FSM, pipeline valids, running minimum and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_sad   <= '0;
      best_index <= '0;
      beat_cnt   <= '0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      run_sad    <= '0;
      run_idx    <= '0;
    end else begin
      done     <= 1'b0;
      s1_valid <= beat_ok;
      s2_valid <= s1_valid;
      if (s2_valid && (s2_sad < run_sad)) begin
        run_sad <= s2_sad;
        run_idx <= s2_idx;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            beat_cnt <= '0;
            run_sad  <= '1;
            run_idx  <= '0;
          end
        end
        RUN: begin
          if (psad_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) state <= DRAIN;
          end
        end
        DRAIN: begin
          // S2 empties on the same edge that S1 is seen empty here.
          if (!s1_valid) state <= DONE;
        end
        DONE: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          best_sad   <= run_sad;
          best_index <= run_idx;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Bench for sad_min_tracker: a default-width instance and a SAD_BIT_WIDTH=12
// instance share all stimulus; a reference model pushes expected results per
// frame and a monitor pops them whenever done pulses.
module tb_sad_min_tracker;
  localparam int P   = 16;
  localparam int E   = 8;
  localparam int PW  = 11;
  localparam int NB  = 16;
  localparam int IW  = 8;
  localparam int BUS = PW * E * P;
`ifdef SAD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic [BUS-1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          psad_valid = 1'b0;
  beat_t         psad_addend_batch = '0;
  logic          busy14, done14, busy12, done12;
  logic [13:0]   best_sad14;
  logic [11:0]   best_sad12;
  logic [IW-1:0] best_index14, best_index12;

  int n_vec = 0;
  int n_err = 0;
  int exp_sad14[$], exp_idx14[$], exp_sad12[$], exp_idx12[$];
  beat_t frame[NB];

  always #5 clk = ~clk;

  sad_min_tracker #(.PIXELS_IN_BATCH(P), .EDGE_LEN(E), .PSAD_BIT_WIDTH(PW),
                    .SAD_BIT_WIDTH(14), .NUM_BATCHES(NB), .INDEX_BIT_WIDTH(IW)) dut14 (
    .clk(clk), .rst(rst), .start(start), .psad_valid(psad_valid),
    .psad_addend_batch(psad_addend_batch), .busy(busy14), .done(done14),
    .best_sad(best_sad14), .best_index(best_index14));

  sad_min_tracker #(.PIXELS_IN_BATCH(P), .EDGE_LEN(E), .PSAD_BIT_WIDTH(PW),
                    .SAD_BIT_WIDTH(12), .NUM_BATCHES(NB), .INDEX_BIT_WIDTH(IW)) dut12 (
    .clk(clk), .rst(rst), .start(start), .psad_valid(psad_valid),
    .psad_addend_batch(psad_addend_batch), .busy(busy12), .done(done12),
    .best_sad(best_sad12), .best_index(best_index12));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t r;
    for (int i = 0; i < BUS/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // mode 0: all ones except beat 5 / candidate 3 zero; 1: all = v; 2: random 0..v
  task automatic fill(input int mode, input int v);
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < E; c++)
        for (int p = 0; p < P; p++) begin
          int x;
          case (mode)
            0:       x = (b == 5 && p == 3) ? 0 : 1;
            1:       x = v;
            default: x = $urandom_range(0, v);
          endcase
          frame[b][(c*P+p)*PW +: PW] = PW'(x);
        end
  endtask

  task automatic model(input int sw, output int bsad, output int bidx);
    int mx;
    bit first;
    mx = (1 << sw) - 1;
    first = 1'b1;
    bsad = 0;
    bidx = 0;
    for (int b = 0; b < NB; b++)
      for (int p = 0; p < P; p++) begin
        int s;
        s = 0;
        for (int c = 0; c < E; c++) s += int'(frame[b][(c*P+p)*PW +: PW]);
        if (SAT) s = (s > mx) ? mx : s;
        else     s = s & mx;
        if (first || s < bsad) begin
          bsad = s;
          bidx = b * P + p;
          first = 1'b0;
        end
      end
  endtask

  // abort_at >= 0 asserts rst together with that beat; no result is expected.
  task automatic run_frame(input int gapmax, input bit noise, input int abort_at);
    int s, i;
    if (abort_at < 0) begin
      model(14, s, i); exp_sad14.push_back(s); exp_idx14.push_back(i);
      model(12, s, i); exp_sad12.push_back(s); exp_idx12.push_back(i);
    end
    @(negedge clk);
    if (noise) begin
      psad_valid = 1'b1; psad_addend_batch = rand_beat();
      @(negedge clk);
    end
    start = 1'b1; psad_valid = noise; psad_addend_batch = rand_beat();
    @(negedge clk);
    start = 1'b0; psad_valid = 1'b0;
    chk("busy_after_start", busy14, 1);
    for (int b = 0; b < NB; b++) begin
      int gap;
      gap = $urandom_range(0, gapmax);
      for (int g = 0; g < gap; g++) begin
        psad_valid = 1'b0; start = noise; psad_addend_batch = rand_beat();
        @(negedge clk);
        chk("busy_gap", busy14, 1);
      end
      start = 1'b0;
      if (b == abort_at) rst = 1'b1;
      psad_valid = 1'b1; psad_addend_batch = frame[b];
      @(negedge clk);
      if (b == abort_at) begin
        rst = 1'b0; psad_valid = 1'b0;
        chk("abort_busy", busy14, 0);
        chk("abort_done", done14, 0);
        chk("abort_sad14", best_sad14, 0);
        chk("abort_idx14", best_index14, 0);
        chk("abort_sad12", best_sad12, 0);
        repeat (8) @(negedge clk);
        return;
      end
      if (b < NB-1) chk("busy_beat", busy14, 1);
    end
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("done14_t%0d", k), done14, (k == 4) ? 1 : 0);
      chk($sformatf("done12_t%0d", k), done12, (k == 4) ? 1 : 0);
      if (k < 4) chk($sformatf("busy_drain_t%0d", k), busy14, 1);
      psad_valid = noise; start = noise && (k < 3);
      psad_addend_batch = rand_beat();
    end
    @(negedge clk);
    start = 1'b0; psad_valid = 1'b0;
    chk("done_width", done14, 0);
  endtask

  // Scoreboard monitor: every done pops one expected result per instance.
  always @(negedge clk) begin
    if (done14) begin
      if (exp_sad14.size() == 0) chk("done14_unexpected", done14, 0);
      else begin
        chk("best_sad14", best_sad14, exp_sad14.pop_front());
        chk("best_idx14", best_index14, exp_idx14.pop_front());
      end
    end
    if (done12) begin
      if (exp_sad12.size() == 0) chk("done12_unexpected", done12, 0);
      else begin
        chk("best_sad12", best_sad12, exp_sad12.pop_front());
        chk("best_idx12", best_index12, exp_idx12.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy14, 0);
    chk("rst_done", done14, 0);
    chk("rst_sad", best_sad14, 0);
    chk("rst_idx", best_index14, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_done", done14, 0);

    fill(0, 0);
    run_frame(0, 1'b0, -1);
    chk("t1_sad", best_sad14, 0);
    chk("t1_idx", best_index14, 83);

    fill(1, 10);
    run_frame(0, 1'b0, -1);
    chk("t2_sad", best_sad14, 80);
    chk("t2_idx", best_index14, 0);

    for (int f = 0; f < 4; f++) begin
      fill(2, 2047);
      run_frame(3, 1'b0, -1);
    end

    fill(2, 2047);
    run_frame(1, 1'b0, 9);
    fill(2, 2047);
    run_frame(2, 1'b0, -1);

    for (int f = 0; f < 2; f++) begin
      fill(2, 500);
      run_frame(2, 1'b1, -1);
    end

    fill(1, 2047);
    run_frame(1, 1'b0, -1);
    chk("full_sad14", best_sad14, 16376);
    chk("full_sad12", best_sad12, SAT ? 4095 : 4088);
    chk("full_idx12", best_index12, 0);

    fill(2, 3);
    run_frame(3, 1'b1, -1);

    repeat (10) @(negedge clk);
    chk("pending14", exp_sad14.size(), 0);
    chk("pending12", exp_sad12.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
